// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_port_arbiter_if : bundle between pipeline/unit/regfile and arbiter      |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
interface wb_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            pipe_valid_i;
  logic [1:0]      pipe_type_i;
  logic [4:0]      pipe_rd_i;
  logic            wb_sel1_o;
  logic            wb_sel2_o;
  logic [XLEN-1:0] wb_data_i;
  logic            lu_valid_i;
  logic            lu_ready_o;
  logic [4:0]      lu_rd_i;
  logic [XLEN-1:0] lu_data_i;
  logic            rf_we_o;
  logic [4:0]      rf_rd_o;
  logic [XLEN-1:0] rf_data_o;
  logic [4:0]      hazard_rd_i;
  logic            pend_hit_o;
  logic            stall_o;

  // Arbiter side
  modport slave (
    input  pipe_valid_i, pipe_type_i, pipe_rd_i, wb_data_i,
    input  lu_valid_i, lu_rd_i, lu_data_i, hazard_rd_i,
    output wb_sel1_o, wb_sel2_o, lu_ready_o,
    output rf_we_o, rf_rd_o, rf_data_o, pend_hit_o, stall_o
  );

  // Pipeline / unit / regfile side
  modport master (
    output pipe_valid_i, pipe_type_i, pipe_rd_i, wb_data_i,
    output lu_valid_i, lu_rd_i, lu_data_i, hazard_rd_i,
    input  wb_sel1_o, wb_sel2_o, lu_ready_o,
    input  rf_we_o, rf_rd_o, rf_data_o, pend_hit_o, stall_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_port_arbiter : regfile write-port arbiter, pipeline vs. unit FIFO       |
// | Option macro: WB_ARB_BYPASS_EN (direct unit-to-regfile path)  Rev 1.0      |
// +--------------------------------------------------------------------------+
module wb_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input wire               clk,
  input wire               rst,
  wb_port_arbiter_if.slave bus
);
  localparam int c_aw   = $clog2(DEPTH);
  localparam int c_agew = $clog2(MAX_WAIT + 1);

  logic [4:0]      r_fifo_rd   [DEPTH];
  logic [XLEN-1:0] r_fifo_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [c_aw:0]   r_count;
  logic [c_agew-1:0] r_age;
  logic            r_we;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_data;
  logic            r_stall;

  logic w_full, w_empty, w_pipe_wr, w_lu_push, w_pop, w_pipe_gnt;
  logic w_byp, w_fifo_wr, w_fifo_hit;

  assign w_full     = (r_count == (c_aw+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pipe_wr  = bus.pipe_valid_i && (bus.pipe_type_i != 2'b11) && (bus.pipe_rd_i != 5'd0);
  assign w_lu_push  = bus.lu_valid_i && !w_full;
  // A raised stall hands the port to the FIFO even over a pipeline write.
  assign w_pop      = !w_empty && (r_stall || !w_pipe_wr);
  assign w_pipe_gnt = w_pipe_wr && !w_pop;
`ifdef WB_ARB_BYPASS_EN
  assign w_byp      = w_lu_push && (bus.lu_rd_i != 5'd0) && w_empty && !w_pipe_wr;
`else
  assign w_byp      = 1'b0;
`endif
  // Results targeting x0 complete the handshake but are never stored.
  assign w_fifo_wr  = w_lu_push && (bus.lu_rd_i != 5'd0) && !w_byp;

  assign bus.wb_sel1_o  = (bus.pipe_type_i == 2'b01);
  assign bus.wb_sel2_o  = (bus.pipe_type_i == 2'b10);
  assign bus.lu_ready_o = !w_full;
  assign bus.rf_we_o    = r_we;
  assign bus.rf_rd_o    = r_rd;
  assign bus.rf_data_o  = r_data;
  assign bus.stall_o    = r_stall;

  always_comb begin
    w_fifo_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      w_fifo_hit = w_fifo_hit || (r_vld[i] && (r_fifo_rd[i] == bus.hazard_rd_i));
  end

  assign bus.pend_hit_o = (bus.hazard_rd_i != 5'd0) &&
                          (w_fifo_hit || (r_we && (r_rd == bus.hazard_rd_i)));

  always_ff @(posedge clk) begin
    if (w_fifo_wr) begin
      r_fifo_rd[r_wptr]   <= bus.lu_rd_i;
      r_fifo_data[r_wptr] <= bus.lu_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_age   <= '0;
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
      r_stall <= 1'b0;
    end else begin
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + 1'b1;
      end
      if (w_fifo_wr) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_fifo_wr && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_fifo_wr && w_pop)
        r_count <= r_count - 1'b1;

      if (w_pop || w_empty)
        r_age <= '0;
      else if (r_age != c_agew'(MAX_WAIT))
        r_age <= r_age + 1'b1;

      r_stall <= (!w_empty && (r_age == c_agew'(MAX_WAIT - 1)) && !w_pop) ||
                 (r_stall && !w_pop);

      r_we <= w_pop || w_pipe_gnt || w_byp;
      if (w_pop) begin
        r_rd   <= r_fifo_rd[r_rptr];
        r_data <= r_fifo_data[r_rptr];
      end else if (w_pipe_gnt) begin
        r_rd   <= bus.pipe_rd_i;
        r_data <= bus.wb_data_i;
      end else if (w_byp) begin
        r_rd   <= bus.lu_rd_i;
        r_data <= bus.lu_data_i;
      end
    end
  end

`ifndef SYNTHESIS
  // The pipeline must be frozen while a stall is requested.
  a_no_pipe_during_stall: assert property (@(posedge clk) disable iff (!rst)
    !(bus.pipe_valid_i && r_stall));
`endif
endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_port_arbiter : directed bench with write-order scoreboard  Rev 1.0   |
// +--------------------------------------------------------------------------+
module tb_wb_port_arbiter;
  localparam int XLEN     = 32;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.XLEN(XLEN)) bus();

  wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_wr(input logic [4:0] rd, input logic [XLEN-1:0] d);
    sb.push_back('{rd: rd, data: d});
  endfunction

  // Advance one clock, then compare any regfile write against the scoreboard head.
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    if (bus.rf_we_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", 64'(bus.rf_we_o), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_rd", 64'(bus.rf_rd_o), 64'(e.rd));
        chk("sb_data", 64'(bus.rf_data_o), 64'(e.data));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    bus.pipe_valid_i = 1'b0;
    bus.pipe_type_i  = 2'b00;
    bus.pipe_rd_i    = '0;
    bus.wb_data_i    = '0;
    bus.lu_valid_i   = 1'b0;
    bus.lu_rd_i      = '0;
    bus.lu_data_i    = '0;
    bus.hazard_rd_i  = 5'd5;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",    64'(bus.rf_we_o),    64'd0);
    chk("rst_rd",    64'(bus.rf_rd_o),    64'd0);
    chk("rst_data",  64'(bus.rf_data_o),  64'd0);
    chk("rst_stall", 64'(bus.stall_o),    64'd0);
    chk("rst_ready", 64'(bus.lu_ready_o), 64'd1);
    chk("rst_pend",  64'(bus.pend_hit_o), 64'd0);
    rst = 1'b1;
    repeat (3) step();
    chk("idle_we",    64'(bus.rf_we_o),    64'd0);
    chk("idle_stall", 64'(bus.stall_o),    64'd0);
    chk("idle_ready", 64'(bus.lu_ready_o), 64'd1);
    chk("idle_pend",  64'(bus.pend_hit_o), 64'd0);

    // Pipeline write, select decode, no-write cases
    bus.pipe_valid_i = 1'b1;
    bus.pipe_type_i  = 2'b01;
    bus.pipe_rd_i    = 5'd5;
    bus.wb_data_i    = 32'h1234;
    #1;
    chk("sel_alu_1", 64'(bus.wb_sel1_o), 64'd1);
    chk("sel_alu_2", 64'(bus.wb_sel2_o), 64'd0);
    expect_wr(5'd5, 32'h1234);
    step();
    chk("pipe_we",   64'(bus.rf_we_o),    64'd1);
    chk("pipe_pend", 64'(bus.pend_hit_o), 64'd1);
    bus.pipe_valid_i = 1'b0;
    bus.pipe_type_i  = 2'b10;
    #1;
    chk("sel_pc4_1", 64'(bus.wb_sel1_o), 64'd0);
    chk("sel_pc4_2", 64'(bus.wb_sel2_o), 64'd1);
    bus.pipe_type_i = 2'b00;
    #1;
    chk("sel_mem_1", 64'(bus.wb_sel1_o), 64'd0);
    chk("sel_mem_2", 64'(bus.wb_sel2_o), 64'd0);
    bus.pipe_valid_i = 1'b1;
    bus.pipe_type_i  = 2'b11;
    step();
    step();
    chk("nowrite_type11_we", 64'(bus.rf_we_o), 64'd0);
    bus.pipe_type_i = 2'b01;
    bus.pipe_rd_i   = 5'd0;
    step();
    step();
    chk("nowrite_rd0_we", 64'(bus.rf_we_o), 64'd0);
    bus.pipe_valid_i = 1'b0;
    step();

    // Single unit result with idle pipeline
    bus.hazard_rd_i = 5'd7;
    bus.lu_valid_i  = 1'b1;
    bus.lu_rd_i     = 5'd7;
    bus.lu_data_i   = 32'hAA;
    #1;
    chk("lu_ready_idle", 64'(bus.lu_ready_o), 64'd1);
    expect_wr(5'd7, 32'hAA);
    step();
    bus.lu_valid_i = 1'b0;
    #1;
`ifdef WB_ARB_BYPASS_EN
    chk("byp_we",   64'(bus.rf_we_o),    64'd1);
    chk("byp_pend", 64'(bus.pend_hit_o), 64'd1);
    step();
    chk("byp_after_pend", 64'(bus.pend_hit_o), 64'd0);
`else
    chk("lu_lat1_we",   64'(bus.rf_we_o),    64'd0);
    chk("lu_lat1_pend", 64'(bus.pend_hit_o), 64'd1);
    step();
    chk("lu_lat2_we",   64'(bus.rf_we_o),    64'd1);
    chk("lu_lat2_pend", 64'(bus.pend_hit_o), 64'd1);
    step();
    chk("lu_after_pend", 64'(bus.pend_hit_o), 64'd0);
`endif

    // Fill FIFO behind continuous pipeline writes, fifth result held
    bus.hazard_rd_i = 5'd0;
    for (int k = 0; k < 4; k++) begin
      bus.pipe_valid_i = 1'b1;
      bus.pipe_type_i  = 2'b01;
      bus.pipe_rd_i    = 5'(20 + k);
      bus.wb_data_i    = 32'(32'h100 + k);
      bus.lu_valid_i   = 1'b1;
      bus.lu_rd_i      = 5'(1 + k);
      bus.lu_data_i    = 32'(32'h500 + k);
      expect_wr(5'(20 + k), 32'(32'h100 + k));
      step();
    end
    chk("full_ready", 64'(bus.lu_ready_o), 64'd0);
    bus.pipe_rd_i  = 5'd24;
    bus.wb_data_i  = 32'h104;
    bus.lu_rd_i    = 5'd5;
    bus.lu_data_i  = 32'h504;
    expect_wr(5'd24, 32'h104);
    step();
    chk("full_hold_ready", 64'(bus.lu_ready_o), 64'd0);
    bus.pipe_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) expect_wr(5'(1 + k), 32'(32'h500 + k));
    accepted = 0;
    for (int t = 0; t < 10 && accepted == 0; t++) begin
      if (bus.lu_ready_o === 1'b1) begin
        expect_wr(5'd5, 32'h504);
        step();
        bus.lu_valid_i = 1'b0;
        accepted = 1;
      end else begin
        step();
      end
    end
    chk("held_accepted", 64'(accepted), 64'd1);
    repeat (6) step();
    chk("order_drained", 64'(sb.size()), 64'd0);

    // Starvation stall
    bus.hazard_rd_i  = 5'd9;
    bus.pipe_valid_i = 1'b1;
    bus.pipe_type_i  = 2'b01;
    bus.pipe_rd_i    = 5'd11;
    bus.wb_data_i    = 32'h900;
    bus.lu_valid_i   = 1'b1;
    bus.lu_rd_i      = 5'd9;
    bus.lu_data_i    = 32'h99;
    expect_wr(5'd11, 32'h900);
    step();
    bus.lu_valid_i = 1'b0;
    for (int s = 2; s <= 9; s++) begin
      bus.wb_data_i = 32'(32'h900 + s);
      expect_wr(5'd11, 32'(32'h900 + s));
      step();
      if (s == 8) chk("stall_before", 64'(bus.stall_o), 64'd0);
    end
    chk("stall_rise", 64'(bus.stall_o), 64'd1);
    bus.pipe_valid_i = 1'b0;
    #1;
    chk("stall_pend", 64'(bus.pend_hit_o), 64'd1);
    expect_wr(5'd9, 32'h99);
    step();
    chk("stall_pop_we", 64'(bus.rf_we_o), 64'd1);
    chk("stall_fall",   64'(bus.stall_o), 64'd0);
    chk("stall_drained", 64'(sb.size()), 64'd0);
    step();

    // Reset with entries queued
    bus.hazard_rd_i = 5'd12;
    for (int k = 0; k < 3; k++) begin
      bus.pipe_valid_i = 1'b1;
      bus.pipe_type_i  = 2'b01;
      bus.pipe_rd_i    = 5'd15;
      bus.wb_data_i    = 32'(32'hC00 + k);
      bus.lu_valid_i   = 1'b1;
      bus.lu_rd_i      = 5'(12 + k);
      bus.lu_data_i    = 32'(32'hD0 + k);
      expect_wr(5'd15, 32'(32'hC00 + k));
      step();
    end
    bus.pipe_valid_i = 1'b0;
    bus.lu_valid_i   = 1'b0;
    #1;
    chk("prerst_pend", 64'(bus.pend_hit_o), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_we",    64'(bus.rf_we_o),    64'd0);
    chk("midrst_pend",  64'(bus.pend_hit_o), 64'd0);
    chk("midrst_ready", 64'(bus.lu_ready_o), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) step();
    chk("postrst_we",   64'(bus.rf_we_o),    64'd0);
    chk("postrst_pend", 64'(bus.pend_hit_o), 64'd0);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
